mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port, variable-latency memory between the pipeline's instruction-fetch
//  port and data (MEM-stage) port. Sits between the pipelined CPU core and a unified memory.
//  Grants one access at a time and returns ready pulses. The core uses these pulses to
//  stall IF or MEM while the access completes.
// PARAMETERS
//  AW           32  address width
//  DW           32  data width
//  STARVE_LIMIT 4   max consecutive data grants while if_req waits; then IF is forced (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  if_req     in   1   fetch request, level, held until if_ready
//  if_addr    in   AW  fetch address
//  if_rdata   out  DW  fetched word, valid while if_ready=1
//  if_ready   out  1   one-cycle completion pulse for fetch
//  dm_req     in   1   data request, level, held until dm_ready
//  dm_we      in   1   1=store, 0=load
//  dm_addr    in   AW  data address
//  dm_wdata   in   DW  store data
//  dm_rdata   out  DW  load data, valid while dm_ready=1 (store: don't-care)
//  dm_ready   out  1   one-cycle completion pulse for data
//  mem_req    out  1   memory request, held until mem_ack
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, valid with mem_ack
//  mem_ack    in   1   memory completion, 1 cycle, only counted while mem_req=1
// BEHAVIOUR
//  - Reset: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
//    Also if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0, starve count=0.
//  - All outputs registered. FSM states: IDLE, BUSY_I, BUSY_D, RESP.
//  - IDLE: samples requests each cycle. Priority: dm_req over if_req.
//    Exception: if_req && dm_req && cnt==STARVE_LIMIT grants IF instead.
//  - Grant at edge N: latches addr/we/wdata of the winner into the mem_* registers.
//    mem_req=1 from cycle N+1. Next state BUSY_I or BUSY_D.
//    mem_we=0 always for IF grants.
//  - BUSY_x: mem_* held stable. On the edge where mem_ack=1: rdata <= mem_rdata,
//    mem_req <= 0, mem_we <= 0, x_ready <= 1, next state RESP.
//  - RESP: ready high exactly one cycle. Requests are ignored. Next state IDLE.
//  - Minimum latency: request in IDLE at cycle N -> mem_req at N+1 -> ack at N+1 -> ready at N+2.
//    Back-to-back throughput is 1 access per 3 cycles at zero wait states.
//  - Starve counter cnt, range 0..STARVE_LIMIT, updated at each grant:
//    - D grant with if_req=1: cnt++ (saturating).
//    - D grant with if_req=0: cnt=0.
//    - any IF grant: cnt=0.
//  - Requester inputs may change after their ready pulse. During BUSY/RESP, request and
//    address inputs have no effect. The latched copy is used.
//  - mem_ack while mem_req=0 (IDLE, RESP): ignored, no state change.
//  - if_ready and dm_ready are never high in the same cycle.
//  - rst mid-BUSY: returns to IDLE next edge, mem_req dropped, no ready pulse.
//    The memory must tolerate the abandoned request.
//  - rdata outputs hold their last value outside the ready cycle.
// TESTING
//  1. IF only: if_addr=0x100, memory acks 1 cycle after mem_req.
//     -> mem_addr=0x100, mem_we=0, if_ready 1 cycle with if_rdata=mem word, dm_ready=0.
//  2. Store only: dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF, ack after 3 wait cycles.
//     -> mem_* stable for all 4 mem_req cycles, dm_ready single pulse.
//  3. Both requests in the same IDLE cycle -> data granted first.
//     IF granted on the next IDLE. Ready pulses are ordered dm then if and never overlap.
//  4. dm_req held continuously (re-asserted each IDLE) with if_req high, STARVE_LIMIT=4.
//     -> grants D,D,D,D,I,D,...; cnt returns to 0 after the IF grant.
//  5. rst asserted in BUSY_D before ack -> mem_req=0 next cycle, no dm_ready.
//     A late mem_ack is ignored. A later if_req is served normally.
//  6. Spurious mem_ack in IDLE and RESP -> no ready pulse, no state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between the fetch port and the data port.
// Data wins ties unless fetch has waited through STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    dbg_state
);

  // Handshake: x_req is a level held until the one-cycle x_ready pulse; mem_req is held
  // with stable we/addr/wdata until a one-cycle mem_ack, and mem_ack is ignored while mem_req=0.

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ready_q, if_ready_d;
  logic          dm_ready_q, dm_ready_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          force_if;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    force_if    = if_req && dm_req && (cnt_q == CW'(STARVE_LIMIT));

    case (state_q)
      IDLE: begin
        if (dm_req && !force_if) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          // Only a waiting fetch makes a data grant count toward starvation.
          if (if_req) begin
            cnt_d = (cnt_q == CW'(STARVE_LIMIT)) ? cnt_q : cnt_q + CW'(1);
          end else begin
            cnt_d = '0;
          end
        end else if (if_req) begin
          state_d    = BUSY_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          cnt_d      = '0;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          dm_rdata_d = mem_rdata;
          dm_ready_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized fetch/data traffic
// checked against a transaction-level model of the two ports and the memory.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, dm_req, dm_we, mem_ack;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic          if_ready, dm_ready, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Memory responder
  logic [DW-1:0] mem_store [logic [AW-1:0]];
  bit mem_en = 1'b0;
  bit rand_wait = 1'b0;
  int wait_cfg = 0;
  int wait_cnt = 0;

  // Monitors
  typedef struct { bit is_if; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } grant_t;
  typedef struct { bit is_if; logic [DW-1:0] rdata; int at; } resp_t;
  grant_t grant_log[$];
  resp_t  resp_log[$];
  int overlap_cnt, unstable_cnt, req_cycles, last_req_cycles, starve_run, max_run;
  logic prev_req;
  logic [AW+DW:0] prev_fields;

  // Reference model for random traffic
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] if_exp_q[$];
  logic [DW-1:0] dm_exp_q[$];
  bit            dm_load_q[$];

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return word_of(a);
  endfunction

  task automatic clear_logs();
    grant_log.delete();
    resp_log.delete();
    overlap_cnt = 0; unstable_cnt = 0; starve_run = 0; max_run = 0;
  endtask

  // One clock: observe outputs #1 after the edge, then play the memory side.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (if_ready === 1'b1 && dm_ready === 1'b1) overlap_cnt++;
    if (if_ready === 1'b1) resp_log.push_back('{1'b1, if_rdata, cyc});
    if (dm_ready === 1'b1) resp_log.push_back('{1'b0, dm_rdata, cyc});
    if (mem_req === 1'b1 && prev_req !== 1'b1) begin
      grant_log.push_back('{dbg_state == S_BUSY_I, mem_we, mem_addr, mem_wdata});
      if (dbg_state == S_BUSY_I) starve_run = 0;
      else if (if_req) begin
        starve_run++;
        if (starve_run > max_run) max_run = starve_run;
      end else starve_run = 0;
    end
    if (mem_req === 1'b1 && prev_req === 1'b1 && {mem_we, mem_addr, mem_wdata} !== prev_fields)
      unstable_cnt++;
    if (mem_req === 1'b1) req_cycles++;
    else if (prev_req === 1'b1) begin
      last_req_cycles = req_cycles;
      req_cycles = 0;
    end
    prev_req    = mem_req;
    prev_fields = {mem_we, mem_addr, mem_wdata};
    if (mem_en) begin
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        if (wait_cnt >= wait_cfg) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_we ? DW'($urandom) : mem_read(mem_addr);
          if (mem_we) mem_store[mem_addr] = mem_wdata;
          wait_cnt  = 0;
          if (rand_wait) wait_cfg = $urandom_range(0, 3);
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    n_checks++;
    if ({mem_req, mem_we, if_ready, dm_ready, dbg_state} !== 6'd0)
      $display("FAIL reset_ctrl: got req=%b we=%b ifr=%b dmr=%b st=%0d, want all 0",
               mem_req, mem_we, if_ready, dm_ready, dbg_state);
    else n_pass++;
    n_checks++;
    if (mem_addr !== '0 || mem_wdata !== '0)
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h, want 0", mem_addr, mem_wdata);
    else n_pass++;
    n_checks++;
    if (if_rdata !== '0 || dm_rdata !== '0)
      $display("FAIL reset_rdata: got if=%h dm=%h, want 0", if_rdata, dm_rdata);
    else n_pass++;
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_if_only();
    int c0;
    clear_logs();
    mem_en = 1'b1; rand_wait = 1'b0; wait_cfg = 1;
    if_req = 1'b1; if_addr = 32'h100;
    c0 = cyc;
    for (int i = 0; i < 20 && resp_log.size() == 0; i++) begin
      cycle();
      if (if_ready) if_req = 1'b0;
    end
    if_req = 1'b0;
    repeat (3) cycle();
    n_checks++;
    if (resp_log.size() != 1 || !resp_log[0].is_if || resp_log[0].rdata !== word_of(32'h100))
      $display("FAIL if_only_resp: got %0d pulses (first is_if=%0d rdata=%h), want 1 fetch pulse rdata=%h",
               resp_log.size(), resp_log.size() ? resp_log[0].is_if : 0,
               resp_log.size() ? resp_log[0].rdata : '0, word_of(32'h100));
    else n_pass++;
    n_checks++;
    if (grant_log.size() != 1 || grant_log[0].addr !== 32'h100 || grant_log[0].we !== 1'b0)
      $display("FAIL if_only_grant: got %0d grants addr=%h we=%b, want 1 grant addr=100 we=0",
               grant_log.size(), grant_log.size() ? grant_log[0].addr : '0,
               grant_log.size() ? grant_log[0].we : 1'b0);
    else n_pass++;
    n_checks++;
    if (resp_log.size() == 0 || resp_log[0].at != c0 + 3 || last_req_cycles != 2)
      $display("FAIL if_only_timing: got ready at +%0d with %0d req cycles, want +3 and 2",
               resp_log.size() ? resp_log[0].at - c0 : -1, last_req_cycles);
    else n_pass++;
  endtask

  task automatic test_store();
    int c0;
    clear_logs();
    wait_cfg = 3;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
    c0 = cyc;
    for (int i = 0; i < 20 && resp_log.size() == 0; i++) begin
      cycle();
      if (dm_ready) dm_req = 1'b0;
    end
    dm_req = 1'b0; dm_we = 1'b0;
    repeat (4) cycle();
    n_checks++;
    if (resp_log.size() != 1 || resp_log[0].is_if || resp_log[0].at != c0 + 5)
      $display("FAIL store_resp: got %0d pulses first_at=+%0d, want 1 data pulse at +5",
               resp_log.size(), resp_log.size() ? resp_log[0].at - c0 : -1);
    else n_pass++;
    n_checks++;
    if (last_req_cycles != 4 || unstable_cnt != 0)
      $display("FAIL store_hold: got %0d req cycles, %0d unstable, want 4 and 0",
               last_req_cycles, unstable_cnt);
    else n_pass++;
    n_checks++;
    if (!mem_store.exists(32'h40) || mem_store[32'h40] !== 32'hDEAD_BEEF ||
        grant_log.size() != 1 || grant_log[0].we !== 1'b1)
      $display("FAIL store_write: got grants=%0d stored=%h, want 1 write of deadbeef",
               grant_log.size(), mem_read(32'h40));
    else n_pass++;
  endtask

  task automatic test_both();
    int c0;
    clear_logs();
    wait_cfg = 0;
    if_req = 1'b1; if_addr = 32'h180;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (dm_ready) dm_req = 1'b0;
      if (if_ready) if_req = 1'b0;
    end
    if_req = 1'b0; dm_req = 1'b0;
    n_checks++;
    if (resp_log.size() != 2 || resp_log[0].is_if || resp_log[0].rdata !== 32'hDEAD_BEEF)
      $display("FAIL both_first: got %0d pulses first is_if=%0d rdata=%h, want data first rdata=deadbeef",
               resp_log.size(), resp_log.size() ? resp_log[0].is_if : 0,
               resp_log.size() ? resp_log[0].rdata : '0);
    else n_pass++;
    n_checks++;
    if (resp_log.size() != 2 || !resp_log[1].is_if || resp_log[1].rdata !== word_of(32'h180))
      $display("FAIL both_second: got is_if=%0d rdata=%h, want fetch rdata=%h",
               resp_log.size() > 1 ? resp_log[1].is_if : 0,
               resp_log.size() > 1 ? resp_log[1].rdata : '0, word_of(32'h180));
    else n_pass++;
    n_checks++;
    if (resp_log.size() != 2 || resp_log[0].at != c0 + 2 || resp_log[1].at != c0 + 5 || overlap_cnt != 0)
      $display("FAIL both_timing: got at +%0d/+%0d overlap=%0d, want +2/+5 overlap=0",
               resp_log.size() ? resp_log[0].at - c0 : -1,
               resp_log.size() > 1 ? resp_log[1].at - c0 : -1, overlap_cnt);
    else n_pass++;
  endtask

  task automatic test_starve();
    bit exp_if;
    clear_logs();
    wait_cfg = 0;
    if_req = 1'b1; if_addr = 32'h1000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    for (int i = 0; i < 80 && grant_log.size() < 10; i++) cycle();
    if_req = 1'b0; dm_req = 1'b0;
    repeat (8) cycle();
    n_checks++;
    if (grant_log.size() < 10)
      $display("FAIL starve_count: got %0d grants, want at least 10", grant_log.size());
    else n_pass++;
    for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
      exp_if = (i % (LIM + 1)) == LIM;
      n_checks++;
      if (grant_log[i].is_if != exp_if)
        $display("FAIL starve_order[%0d]: got is_if=%0d, want %0d", i, grant_log[i].is_if, exp_if);
      else n_pass++;
    end
    n_checks++;
    if (max_run != LIM || overlap_cnt != 0)
      $display("FAIL starve_run: got max %0d overlap %0d, want %0d and 0", max_run, overlap_cnt, LIM);
    else n_pass++;
  endtask

  task automatic test_rst_busy();
    clear_logs();
    mem_en = 1'b0; mem_ack = 1'b0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = $urandom;
    cycle();
    n_checks++;
    if (dbg_state !== S_BUSY_D || mem_req !== 1'b1)
      $display("FAIL rst_busy_pre: got st=%0d req=%b, want %0d and 1", dbg_state, mem_req, S_BUSY_D);
    else n_pass++;
    cycle();
    rst = 1'b1;
    cycle();
    n_checks++;
    if (mem_req !== 1'b0 || dm_ready !== 1'b0 || dbg_state !== S_IDLE)
      $display("FAIL rst_busy_drop: got req=%b dmr=%b st=%0d, want 0 0 %0d",
               mem_req, dm_ready, dbg_state, S_IDLE);
    else n_pass++;
    rst = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    cycle();
    n_checks++;
    if (resp_log.size() != 0 || dbg_state !== S_IDLE || mem_req !== 1'b0)
      $display("FAIL rst_busy_late_ack: got %0d pulses st=%0d req=%b, want 0 %0d 0",
               resp_log.size(), dbg_state, mem_req, S_IDLE);
    else n_pass++;
    mem_en = 1'b1; wait_cfg = 0;
    if_req = 1'b1; if_addr = 32'h1234;
    for (int i = 0; i < 20 && resp_log.size() == 0; i++) begin
      cycle();
      if (if_ready) if_req = 1'b0;
    end
    if_req = 1'b0;
    n_checks++;
    if (resp_log.size() != 1 || !resp_log[0].is_if || resp_log[0].rdata !== word_of(32'h1234))
      $display("FAIL rst_busy_after: got %0d pulses rdata=%h, want 1 fetch rdata=%h",
               resp_log.size(), resp_log.size() ? resp_log[0].rdata : '0, word_of(32'h1234));
    else n_pass++;
    cycle();
  endtask

  task automatic test_spurious();
    bit saw_resp;
    clear_logs();
    mem_en = 1'b0;
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    cycle();
    n_checks++;
    if (dbg_state !== S_IDLE || mem_req !== 1'b0 || resp_log.size() != 0)
      $display("FAIL spurious_idle: got st=%0d req=%b pulses=%0d, want %0d 0 0",
               dbg_state, mem_req, resp_log.size(), S_IDLE);
    else n_pass++;
    mem_en = 1'b1; wait_cfg = 0;
    if_req = 1'b1; if_addr = 32'h1400;
    saw_resp = 1'b0;
    for (int i = 0; i < 20 && !saw_resp; i++) begin
      cycle();
      if (if_ready) begin
        if_req = 1'b0;
        saw_resp = (dbg_state === S_RESP);
        mem_en = 1'b0;
        mem_ack = 1'b1;
      end
    end
    cycle();
    mem_ack = 1'b0;
    n_checks++;
    if (!saw_resp || dbg_state !== S_IDLE || if_ready !== 1'b0 || dm_ready !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL spurious_resp: got resp_seen=%0d st=%0d ifr=%b dmr=%b req=%b, want 1 %0d 0 0 0",
               saw_resp, dbg_state, if_ready, dm_ready, mem_req, S_IDLE);
    else n_pass++;
    mem_en = 1'b1;
    repeat (2) cycle();
  endtask

  task automatic test_random();
    logic [DW-1:0] e;
    bit            is_load;
    int            served = 0;
    clear_logs();
    mem_store.delete(); ref_mem.delete();
    mem_en = 1'b1; rand_wait = 1'b1; wait_cfg = $urandom_range(0, 3);
    for (int i = 0; i < 900; i++) begin
      cycle();
      if (if_ready) begin
        n_checks++;
        if (if_exp_q.size() == 0) $display("FAIL rand_if_extra: unexpected fetch pulse rdata=%h", if_rdata);
        else begin
          e = if_exp_q.pop_front();
          if (if_rdata !== e) $display("FAIL rand_if_rdata: got %h, want %h", if_rdata, e);
          else n_pass++;
        end
        if_req = 1'b0;
        served++;
      end
      if (dm_ready) begin
        if (dm_load_q.size() == 0) begin
          n_checks++;
          $display("FAIL rand_dm_extra: unexpected data pulse rdata=%h", dm_rdata);
        end else begin
          is_load = dm_load_q.pop_front();
          e = dm_exp_q.pop_front();
          if (is_load) begin
            n_checks++;
            if (dm_rdata !== e) $display("FAIL rand_dm_rdata: got %h, want %h", dm_rdata, e);
            else n_pass++;
          end
        end
        dm_req = 1'b0;
        served++;
      end
      if (i < 800 && !if_req && $urandom_range(0, 2) != 0) begin
        if_req  = 1'b1;
        if_addr = 32'h1000 + AW'($urandom_range(0, 1023) * 4);
        if_exp_q.push_back(word_of(if_addr));
      end
      if (i < 800 && !dm_req && $urandom_range(0, 2) != 0) begin
        dm_req   = 1'b1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = AW'($urandom_range(0, 63) * 4);
        dm_wdata = $urandom;
        if (dm_we) begin
          ref_mem[dm_addr] = dm_wdata;
          dm_load_q.push_back(1'b0);
          dm_exp_q.push_back('0);
        end else begin
          dm_load_q.push_back(1'b1);
          dm_exp_q.push_back(ref_mem.exists(dm_addr) ? ref_mem[dm_addr] : word_of(dm_addr));
        end
      end
    end
    n_checks++;
    if (if_exp_q.size() != 0 || dm_load_q.size() != 0 || served < 50)
      $display("FAIL rand_drain: got %0d fetch / %0d data pending, %0d served, want 0/0 and >=50",
               if_exp_q.size(), dm_load_q.size(), served);
    else n_pass++;
    n_checks++;
    if (overlap_cnt != 0 || unstable_cnt != 0 || max_run > LIM)
      $display("FAIL rand_rules: got overlap=%0d unstable=%0d max_starve=%0d, want 0 0 <=%0d",
               overlap_cnt, unstable_cnt, max_run, LIM);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    prev_req = 1'b0; prev_fields = '0; req_cycles = 0; last_req_cycles = 0;
    test_reset();
    test_if_only();
    test_store();
    test_both();
    test_starve();
    test_rst_busy();
    test_spurious();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
